raster_engine: RTL and testbench

GPU-side responder for the CPU-GPU command interface. It accepts one raster command per execute request: FILL, POINT, LINE or RECT. It then walks the covered pixels and emits one framebuffer write per pixel over a ready/valid pixel port. It holds busy for the whole command so the CPU can sequence draws.

---
 rtl/common_pkg.sv | 18 +
 rtl/gpu_common_pkg.sv | 28 ++
 rtl/raster_engine_line_stepper.sv | 100 ++++++++++
 rtl/raster_engine.sv | 194 +++++++++++++++++++
 tb/tb_raster_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// +--------------------------------------------------------------------+
// | common : command encodings shared by the CPU and GPU sides         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package common;

    typedef enum logic [1:0] {
        RASTER_CMD_FILL  = 2'd0,
        RASTER_CMD_POINT = 2'd1,
        RASTER_CMD_LINE  = 2'd2,
        RASTER_CMD_RECT  = 2'd3
    } raster_command_t;

endpackage

`default_nettype wire

// File: rtl/gpu_common_pkg.sv
// +--------------------------------------------------------------------+
// | gpu_common : raster engine state encoding and screen geometry      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package gpu_common;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } raster_state_t;

    localparam int DEFAULT_WIDTH  = 214;
    localparam int DEFAULT_HEIGHT = 160;

    function automatic logic [8:0] min9(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? {1'b0, a} : {1'b0, b};
    endfunction

    function automatic logic [8:0] max9(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? {1'b0, a} : {1'b0, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/raster_engine_line_stepper.sv
// +--------------------------------------------------------------------+
// | line_stepper : Bresenham walker, one pixel per step, all octants   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module line_stepper (
    input  logic       clk,
    input  logic       rst_async,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [7:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [7:0] x1_i,
    input  logic [7:0] y1_i,
    output logic [7:0] x_o,
    output logic [7:0] y_o,
    output logic       done_o
);

    logic [7:0]        x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
    logic [9:0]        adx_q, adx_d, ady_q, ady_d;
    logic              sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [9:0] err_q, err_d;
    logic signed [9:0] dx_w, dy_w;
    logic signed [10:0] e2_w, adx_ext_w, ady_ext_w;
    logic              step_x_w, step_y_w;

    always_comb begin
        dx_w      = $signed({2'b00, x1_i}) - $signed({2'b00, x0_i});
        dy_w      = $signed({2'b00, y1_i}) - $signed({2'b00, y0_i});
        e2_w      = {err_q, 1'b0};
        adx_ext_w = {1'b0, adx_q};
        ady_ext_w = {1'b0, ady_q};
        // Both decisions use the pre-step error so x and y can move together.
        step_x_w  = (e2_w > -ady_ext_w);
        step_y_w  = (e2_w < adx_ext_w);

        x_d      = x_q;
        y_d      = y_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        adx_d    = adx_q;
        ady_d    = ady_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;

        if (load_i) begin
            x_d      = x0_i;
            y_d      = y0_i;
            x1_d     = x1_i;
            y1_d     = y1_i;
            sx_neg_d = dx_w[9];
            sy_neg_d = dy_w[9];
            adx_d    = dx_w[9] ? -dx_w : dx_w;
            ady_d    = dy_w[9] ? -dy_w : dy_w;
            err_d    = adx_d - ady_d;
        end else if (step_i) begin
            err_d = err_q - (step_x_w ? ady_q : 10'd0) + (step_y_w ? adx_q : 10'd0);
            if (step_x_w) begin
                x_d = x_q + (sx_neg_q ? 8'hFF : 8'h01);
            end
            if (step_y_w) begin
                y_d = y_q + (sy_neg_q ? 8'hFF : 8'h01);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            adx_q    <= '0;
            ady_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            adx_q    <= adx_d;
            ady_q    <= ady_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = (x_q == x1_q) && (y_q == y1_q);

endmodule

`default_nettype wire

// File: rtl/raster_engine.sv
// +--------------------------------------------------------------------+
// | raster_engine : walks FILL/POINT/LINE/RECT pixels to a framebuffer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module raster_engine
    import common::*;
    import gpu_common::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic            clk,
    input  logic            rst_async,
    input  raster_command_t gpu_command,
    input  logic [7:0]      gpu_x0,
    input  logic [7:0]      gpu_y0,
    input  logic [7:0]      gpu_x1,
    input  logic [7:0]      gpu_y1,
    input  logic [2:0]      gpu_colour,
    input  logic            gpu_execute_request,
    output logic            gpu_busy,
    output logic [7:0]      fb_x,
    output logic [7:0]      fb_y,
    output logic [2:0]      fb_colour,
    output logic            fb_write,
    input  logic            fb_ready
);

    localparam logic [8:0] c_WIDTH9  = WIDTH[8:0];
    localparam logic [8:0] c_HEIGHT9 = HEIGHT[8:0];

    raster_state_t   state_q, state_d;
    raster_command_t cmd_q, cmd_d;
    logic [7:0]      x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [2:0]      colour_q, colour_d;
    logic            is_line_q, is_line_d;
    logic [8:0]      xl_q, xl_d, xh_q, xh_d, yh_q, yh_d;
    logic [8:0]      scan_x_q, scan_x_d, scan_y_q, scan_y_d;

    logic [7:0]      ls_x_w, ls_y_w;
    logic            ls_done_w, ls_load_w, ls_step_w;
    logic [8:0]      cur_x_w, cur_y_w;
    logic            in_draw_w, on_screen_w, advance_w, last_px_w;

    line_stepper u_line_stepper (
        .clk       (clk),
        .rst_async (rst_async),
        .load_i    (ls_load_w),
        .step_i    (ls_step_w),
        .x0_i      (x0_q),
        .y0_i      (y0_q),
        .x1_i      (x1_q),
        .y1_i      (y1_q),
        .x_o       (ls_x_w),
        .y_o       (ls_y_w),
        .done_o    (ls_done_w)
    );

    always_comb begin
        cur_x_w     = is_line_q ? {1'b0, ls_x_w} : scan_x_q;
        cur_y_w     = is_line_q ? {1'b0, ls_y_w} : scan_y_q;
        in_draw_w   = (state_q == DRAW);
        on_screen_w = (cur_x_w < c_WIDTH9) && (cur_y_w < c_HEIGHT9);
        // Clipped pixels retire without waiting for the framebuffer.
        advance_w   = in_draw_w && (!on_screen_w || fb_ready);
        last_px_w   = is_line_q ? ls_done_w : ((scan_x_q == xh_q) && (scan_y_q == yh_q));
        ls_load_w   = (state_q == SETUP) && (cmd_q == RASTER_CMD_LINE);
        ls_step_w   = advance_w && is_line_q && !last_px_w;
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        colour_d  = colour_q;
        is_line_d = is_line_q;
        xl_d      = xl_q;
        xh_d      = xh_q;
        yh_d      = yh_q;
        scan_x_d  = scan_x_q;
        scan_y_d  = scan_y_q;

        case (state_q)
            IDLE: begin
                if (gpu_execute_request) begin
                    cmd_d    = gpu_command;
                    x0_d     = gpu_x0;
                    y0_d     = gpu_y0;
                    x1_d     = gpu_x1;
                    y1_d     = gpu_y1;
                    colour_d = gpu_colour;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d   = DRAW;
                is_line_d = 1'b0;
                case (cmd_q)
                    RASTER_CMD_FILL: begin
                        xl_d     = 9'd0;
                        xh_d     = c_WIDTH9 - 9'd1;
                        yh_d     = c_HEIGHT9 - 9'd1;
                        scan_x_d = 9'd0;
                        scan_y_d = 9'd0;
                    end
                    RASTER_CMD_POINT: begin
                        xl_d     = {1'b0, x0_q};
                        xh_d     = {1'b0, x0_q};
                        yh_d     = {1'b0, y0_q};
                        scan_x_d = {1'b0, x0_q};
                        scan_y_d = {1'b0, y0_q};
                    end
                    RASTER_CMD_RECT: begin
                        xl_d     = min9(x0_q, x1_q);
                        xh_d     = max9(x0_q, x1_q);
                        yh_d     = max9(y0_q, y1_q);
                        scan_x_d = min9(x0_q, x1_q);
                        scan_y_d = min9(y0_q, y1_q);
                    end
                    RASTER_CMD_LINE: begin
                        is_line_d = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            DRAW: begin
                if (advance_w) begin
                    if (last_px_w) begin
                        state_d = IDLE;
                    end else if (!is_line_q) begin
                        // 9-bit counters let xh=255 finish without wrapping.
                        if (scan_x_q == xh_q) begin
                            scan_x_d = xl_q;
                            scan_y_d = scan_y_q + 9'd1;
                        end else begin
                            scan_x_d = scan_x_q + 9'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state_q   <= IDLE;
            cmd_q     <= RASTER_CMD_FILL;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            colour_q  <= '0;
            is_line_q <= 1'b0;
            xl_q      <= '0;
            xh_q      <= '0;
            yh_q      <= '0;
            scan_x_q  <= '0;
            scan_y_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            colour_q  <= colour_d;
            is_line_q <= is_line_d;
            xl_q      <= xl_d;
            xh_q      <= xh_d;
            yh_q      <= yh_d;
            scan_x_q  <= scan_x_d;
            scan_y_q  <= scan_y_d;
        end
    end

    assign gpu_busy  = (state_q != IDLE);
    assign fb_write  = in_draw_w && on_screen_w;
    assign fb_x      = in_draw_w ? cur_x_w[7:0] : 8'd0;
    assign fb_y      = in_draw_w ? cur_y_w[7:0] : 8'd0;
    assign fb_colour = in_draw_w ? colour_q : 3'd0;

endmodule

`default_nettype wire

// File: tb/tb_raster_engine.sv
// +--------------------------------------------------------------------+
// | tb_raster_engine : randomized self-checking bench for raster_engine|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_raster_engine;
    import common::*;

    localparam int W = 214;
    localparam int H = 160;

    logic            clk = 1'b0;
    logic            rst_async = 1'b0;
    raster_command_t gpu_command = RASTER_CMD_POINT;
    logic [7:0]      gpu_x0 = '0, gpu_y0 = '0, gpu_x1 = '0, gpu_y1 = '0;
    logic [2:0]      gpu_colour = '0;
    logic            gpu_execute_request = 1'b0;
    logic            gpu_busy;
    logic [7:0]      fb_x, fb_y;
    logic [2:0]      fb_colour;
    logic            fb_write;
    logic            fb_ready = 1'b1;

    raster_engine dut (
        .clk                 (clk),
        .rst_async           (rst_async),
        .gpu_command         (gpu_command),
        .gpu_x0              (gpu_x0),
        .gpu_y0              (gpu_y0),
        .gpu_x1              (gpu_x1),
        .gpu_y1              (gpu_y1),
        .gpu_colour          (gpu_colour),
        .gpu_execute_request (gpu_execute_request),
        .gpu_busy            (gpu_busy),
        .fb_x                (fb_x),
        .fb_y                (fb_y),
        .fb_colour           (fb_colour),
        .fb_write            (fb_write),
        .fb_ready            (fb_ready)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int got_q[$];
    int gotc_q[$];
    int stall_bad;

    // Expected pixel list (x*256+y) straight from the drawing rules, with clipping.
    function automatic void build_exp(input raster_command_t c, input int x0, input int y0,
                                      input int x1, input int y1);
        int x, y, dx, dy, adx, ady, sx, sy, err, e2;
        exp_q.delete();
        case (c)
            RASTER_CMD_FILL:
                for (int yy = 0; yy < H; yy++)
                    for (int xx = 0; xx < W; xx++) exp_q.push_back(xx * 256 + yy);
            RASTER_CMD_POINT:
                if (x0 < W && y0 < H) exp_q.push_back(x0 * 256 + y0);
            RASTER_CMD_RECT:
                for (int yy = (y0 < y1 ? y0 : y1); yy <= (y0 > y1 ? y0 : y1); yy++)
                    for (int xx = (x0 < x1 ? x0 : x1); xx <= (x0 > x1 ? x0 : x1); xx++)
                        if (xx < W && yy < H) exp_q.push_back(xx * 256 + yy);
            default: begin
                x = x0; y = y0; dx = x1 - x0; dy = y1 - y0;
                adx = dx < 0 ? -dx : dx; ady = dy < 0 ? -dy : dy;
                sx = dx < 0 ? -1 : 1; sy = dy < 0 ? -1 : 1;
                err = adx - ady;
                forever begin
                    if (x < W && y < H) exp_q.push_back(x * 256 + y);
                    if (x == x1 && y == y1) break;
                    e2 = 2 * err;
                    if (e2 > -ady) begin err -= ady; x += sx; end
                    if (e2 < adx) begin err += adx; y += sy; end
                end
            end
        endcase
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int colour_bad(input int col);
        foreach (gotc_q[i]) if (gotc_q[i] != col) return 1;
        return 0;
    endfunction

    // Called at a negedge in IDLE; returns at the first negedge with busy low.
    task automatic run_cmd(input raster_command_t c, input logic [7:0] ax0, input logic [7:0] ay0,
                           input logic [7:0] ax1, input logic [7:0] ay1, input logic [2:0] col,
                           input int rmode, input int inject_at, input int limit,
                           output int busy_cycles, output bit timeout);
        int cyc;
        bit prev_stall;
        logic [19:0] prev_out, cur_out;
        got_q.delete(); gotc_q.delete();
        stall_bad = 0; timeout = 0; prev_stall = 0; prev_out = '0;
        gpu_command = c; gpu_x0 = ax0; gpu_y0 = ay0; gpu_x1 = ax1; gpu_y1 = ay1;
        gpu_colour = col; gpu_execute_request = 1'b1;
        @(negedge clk);
        gpu_execute_request = 1'b0;
        busy_cycles = 0; cyc = 0;
        while (gpu_busy) begin
            busy_cycles++;
            if (cyc == inject_at) begin
                gpu_command = RASTER_CMD_POINT; gpu_x0 = 8'd1; gpu_y0 = 8'd1;
                gpu_colour = 3'd7; gpu_execute_request = 1'b1;
            end else begin
                gpu_execute_request = 1'b0;
            end
            case (rmode)
                0: fb_ready = 1'b1;
                1: fb_ready = (cyc % 2 == 0);
                default: fb_ready = ($urandom_range(0, 3) != 0);
            endcase
            cur_out = {fb_write, fb_colour, fb_x, fb_y};
            if (prev_stall && cur_out !== prev_out) stall_bad++;
            if (fb_write && fb_ready) begin
                got_q.push_back(int'(fb_x) * 256 + int'(fb_y));
                gotc_q.push_back(int'(fb_colour));
            end
            prev_stall = fb_write && !fb_ready;
            prev_out = cur_out;
            @(negedge clk);
            cyc++;
            if (cyc > limit) begin timeout = 1; break; end
        end
        gpu_execute_request = 1'b0;
        fb_ready = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({gpu_busy, fb_write, fb_x, fb_y, fb_colour} !== 22'd0)
            begin errors++; $display("FAIL reset_state: got busy=%b wr=%b x=%0d y=%0d c=%0d, need all 0",
                                     gpu_busy, fb_write, fb_x, fb_y, fb_colour); end
    endtask

    task automatic test_point();
        fb_ready = 1'b1;
        gpu_command = RASTER_CMD_POINT; gpu_x0 = 8'd100; gpu_y0 = 8'd100;
        gpu_x1 = 8'd0; gpu_y1 = 8'd0; gpu_colour = 3'b110; gpu_execute_request = 1'b1;
        @(negedge clk);
        gpu_execute_request = 1'b0;
        checks++;
        if (gpu_busy !== 1'b1 || fb_write !== 1'b0)
            begin errors++; $display("FAIL point_n1: busy=%b wr=%b, need busy=1 wr=0", gpu_busy, fb_write); end
        @(negedge clk);
        checks++;
        if ({fb_write, fb_x, fb_y, fb_colour} !== {1'b1, 8'd100, 8'd100, 3'd6})
            begin errors++; $display("FAIL point_n2: wr=%b (%0d,%0d) c=%0d, need wr=1 (100,100) c=6",
                                     fb_write, fb_x, fb_y, fb_colour); end
        @(negedge clk);
        checks++;
        if (gpu_busy !== 1'b0 || fb_write !== 1'b0)
            begin errors++; $display("FAIL point_n3: busy=%b wr=%b, need 0 0", gpu_busy, fb_write); end
    endtask

    task automatic test_line_directed();
        logic [7:0] tab[3][4] = '{'{8'd10, 8'd10, 8'd13, 8'd12},
                                   '{8'd5, 8'd5, 8'd5, 8'd1},
                                   '{8'd7, 8'd3, 8'd7, 8'd3}};
        int need_n[3] = '{4, 5, 1};
        int bc, d; bit to;
        for (int t = 0; t < 3; t++) begin
            build_exp(RASTER_CMD_LINE, tab[t][0], tab[t][1], tab[t][2], tab[t][3]);
            run_cmd(RASTER_CMD_LINE, tab[t][0], tab[t][1], tab[t][2], tab[t][3], 3'd2, 0, -1, 600, bc, to);
            d = first_diff();
            checks++;
            if (to || got_q.size() != need_n[t])
                begin errors++; $display("FAIL line_count[%0d]: got %0d pixels timeout=%b, need %0d", t, got_q.size(), to, need_n[t]); end
            checks++;
            if (d >= 0)
                begin errors++; $display("FAIL line_seq[%0d]: idx %0d got %0h need %0h", t, d,
                                         d < got_q.size() ? got_q[d] : -1, d < exp_q.size() ? exp_q[d] : -1); end
            checks++;
            if (got_q.size() == 0 || got_q[got_q.size()-1] != int'(tab[t][2]) * 256 + int'(tab[t][3]))
                begin errors++; $display("FAIL line_endpoint[%0d]: last pixel is not the endpoint", t); end
            checks++;
            if (bc != need_n[t] + 1 || fb_write !== 1'b0)
                begin errors++; $display("FAIL line_busy[%0d]: busy %0d cycles wr=%b, need %0d wr=0", t, bc, fb_write, need_n[t] + 1); end
        end
    endtask

    task automatic test_rect_stall();
        int bc, d; bit to;
        build_exp(RASTER_CMD_RECT, 204, 130, 202, 129);
        run_cmd(RASTER_CMD_RECT, 8'd204, 8'd130, 8'd202, 8'd129, 3'd3, 1, -1, 200, bc, to);
        d = first_diff();
        checks++;
        if (to || d >= 0 || got_q.size() != 6)
            begin errors++; $display("FAIL rect_stall_seq: %0d pixels, first diff %0d, need 6 row-major", got_q.size(), d); end
        checks++;
        if (stall_bad != 0)
            begin errors++; $display("FAIL rect_stall_hold: %0d unstable stall cycles, need 0", stall_bad); end
        checks++;
        if (bc != 13)
            begin errors++; $display("FAIL rect_stall_busy: busy %0d cycles, need 13", bc); end
    endtask

    task automatic test_fill();
        int bc, d; bit to;
        build_exp(RASTER_CMD_FILL, 0, 0, 0, 0);
        run_cmd(RASTER_CMD_FILL, 8'd9, 8'd9, 8'd9, 8'd9, 3'b101, 0, 1000, 40000, bc, to);
        d = first_diff();
        checks++;
        if (to || got_q.size() != W * H)
            begin errors++; $display("FAIL fill_count: got %0d timeout=%b, need %0d", got_q.size(), to, W * H); end
        checks++;
        if (got_q.size() == 0 || got_q[0] != 0 || got_q[got_q.size()-1] != (W-1) * 256 + (H-1))
            begin errors++; $display("FAIL fill_ends: first/last pixel wrong"); end
        checks++;
        if (d >= 0)
            begin errors++; $display("FAIL fill_seq: first diff at %0d", d); end
        checks++;
        if (colour_bad(5) != 0)
            begin errors++; $display("FAIL fill_colour: a pixel colour differs from 5"); end
        checks++;
        if (bc != W * H + 1)
            begin errors++; $display("FAIL fill_busy: busy %0d cycles, need %0d", bc, W * H + 1); end
    endtask

    task automatic test_clip();
        int bc, d; bit to;
        build_exp(RASTER_CMD_RECT, 210, 158, 220, 165);
        run_cmd(RASTER_CMD_RECT, 8'd210, 8'd158, 8'd220, 8'd165, 3'd4, 0, -1, 500, bc, to);
        d = first_diff();
        checks++;
        if (to || got_q.size() != 8 || d >= 0)
            begin errors++; $display("FAIL clip_rect: got %0d pixels diff %0d, need 8", got_q.size(), d); end
        checks++;
        if (bc != 1 + 11 * 8)
            begin errors++; $display("FAIL clip_busy: busy %0d cycles, need %0d", bc, 1 + 11 * 8); end
    endtask

    task automatic test_random();
        raster_command_t c;
        logic [7:0] a, b, e, f;
        logic [2:0] col;
        int bc, d, k; bit to;
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 2);
            c = (k == 0) ? RASTER_CMD_POINT : (k == 1) ? RASTER_CMD_LINE : RASTER_CMD_RECT;
            a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            if (c == RASTER_CMD_RECT) begin
                e = 8'(int'(a) + int'($urandom_range(0, 15)) > 255 ? 255 : int'(a) + int'($urandom_range(0, 15)));
                f = 8'(int'(b) < 12 ? 0 : int'(b) - int'($urandom_range(0, 12)));
            end else begin
                e = 8'($urandom_range(0, 255)); f = 8'($urandom_range(0, 255));
            end
            col = 3'($urandom_range(0, 7));
            build_exp(c, a, b, e, f);
            run_cmd(c, a, b, e, f, col, 2, -1, 5000, bc, to);
            d = first_diff();
            checks++;
            if (to || d >= 0)
                begin errors++; $display("FAIL rand_seq[%0d]: cmd=%0d (%0d,%0d)->(%0d,%0d) diff %0d got %0d need %0d",
                                         n, c, a, b, e, f, d, got_q.size(), exp_q.size()); end
            checks++;
            if (colour_bad(int'(col)) != 0 || stall_bad != 0)
                begin errors++; $display("FAIL rand_colour_hold[%0d]: stall_bad=%0d", n, stall_bad); end
        end
    endtask

    task automatic test_reset_mid();
        int n, cyc, bc; bit to;
        fb_ready = 1'b1;
        gpu_command = RASTER_CMD_LINE; gpu_x0 = 8'd0; gpu_y0 = 8'd0;
        gpu_x1 = 8'd60; gpu_y1 = 8'd20; gpu_colour = 3'd1; gpu_execute_request = 1'b1;
        @(negedge clk);
        gpu_execute_request = 1'b0;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 50) begin
            @(negedge clk);
            if (fb_write) n++;
            cyc++;
        end
        @(posedge clk);
        #2 rst_async = 1'b0;
        #1;
        checks++;
        if (gpu_busy !== 1'b0 || fb_write !== 1'b0 || n != 3)
            begin errors++; $display("FAIL reset_mid: busy=%b wr=%b seen=%0d, need 0 0 3", gpu_busy, fb_write, n); end
        @(negedge clk); @(negedge clk);
        rst_async = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fb_write || gpu_busy) n++;
        end
        checks++;
        if (n != 0)
            begin errors++; $display("FAIL reset_stale: %0d active cycles after release, need 0", n); end
        run_cmd(RASTER_CMD_POINT, 8'd20, 8'd30, 8'd0, 8'd0, 3'd2, 0, -1, 20, bc, to);
        checks++;
        if (to || got_q.size() != 1 || got_q[0] != 20 * 256 + 30 || gotc_q[0] != 2)
            begin errors++; $display("FAIL reset_point: got %0d pixels, need one (20,30) c=2", got_q.size()); end
    endtask

    task automatic test_back_to_back();
        int bc, d; bit to;
        build_exp(RASTER_CMD_POINT, 3, 4, 0, 0);
        run_cmd(RASTER_CMD_POINT, 8'd3, 8'd4, 8'd0, 8'd0, 3'd7, 0, -1, 20, bc, to);
        checks++;
        if (to || first_diff() >= 0)
            begin errors++; $display("FAIL b2b_first: got %0d pixels, need 1", got_q.size()); end
        build_exp(RASTER_CMD_LINE, 200, 150, 220, 140);
        run_cmd(RASTER_CMD_LINE, 8'd200, 8'd150, 8'd220, 8'd140, 3'd6, 0, -1, 100, bc, to);
        d = first_diff();
        checks++;
        if (to || d >= 0 || bc != 22)
            begin errors++; $display("FAIL b2b_second: %0d pixels diff %0d busy %0d, need %0d and busy 22",
                                     got_q.size(), d, bc, exp_q.size()); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_async = 1'b1;
        @(negedge clk);
        test_reset();
        test_point();
        test_line_directed();
        test_rect_stall();
        test_clip();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
